// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: widths, reset PC, halt encoding and the
// fetch-state enum, so instruction memory, fetch and decode agree on them.
package mips_pkg;

  localparam int unsigned           ADDR_W    = 6;
  localparam int unsigned           DATA_W    = 32;
  localparam int unsigned           CNT_W     = 16;
  localparam logic [ADDR_W-1:0]     RESET_PC  = 6'h00;
  localparam logic [DATA_W-1:0]     HALT_WORD = 32'hFC00_0000;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port: fetch drives the word address, memory returns
// the instruction combinationally in the same cycle.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned DATA_W = mips_pkg::DATA_W
);

  logic [ADDR_W-1:0] ReadAddress;
  logic [DATA_W-1:0] Instruction;

  // Fetch unit side
  modport master (
    output ReadAddress,
    input  Instruction
  );

  // Instruction memory side
  modport slave (
    input  ReadAddress,
    output Instruction
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register holding {valid, instruction, pc}. Flush clears only
// the valid bit so the last instruction/pc stay visible; load captures a new
// fetch; neither holds everything (stall).
module if_id_register #(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;

  // Flush has priority over load; otherwise contents are held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address,
// captures the returned word into IF/ID and handles stall, redirect, halt
// detection and a saturating fetch counter.
module instruction_fetch_unit
  import mips_pkg::fetch_state_e, mips_pkg::FS_IDLE, mips_pkg::FS_RUN, mips_pkg::FS_HALTED;
#(
  parameter int unsigned       ADDR_W    = mips_pkg::ADDR_W,
  parameter int unsigned       DATA_W    = mips_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [DATA_W-1:0] HALT_WORD = mips_pkg::HALT_WORD,
  parameter int unsigned       CNT_W     = mips_pkg::CNT_W
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic                     Start,
  input  logic                     Stall,
  input  logic                     Redirect,
  input  logic [ADDR_W-1:0]        RedirectTarget,
  instruction_fetch_unit_if.master imem,
  output logic                     IfValid,
  output logic [DATA_W-1:0]        IfInstruction,
  output logic [ADDR_W-1:0]        IfPc,
  output logic                     Halted,
  output logic [CNT_W-1:0]         FetchCount
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_flush;
  logic              w_is_halt;

  assign w_is_halt = (imem.Instruction == HALT_WORD);

  // Fetch-state register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) r_state <= FS_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state, next PC and IF/ID control; priority Redirect > Stall > halt > fetch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_accept     = 1'b0;
    w_flush      = 1'b1;
    unique case (r_state)
      FS_IDLE: begin
        if (Redirect) w_pc_next    = RedirectTarget;
        if (Start)    w_state_next = FS_RUN;
      end
      FS_RUN: begin
        if (Redirect) begin
          w_pc_next = RedirectTarget;
        end else if (Stall) begin
          w_flush = 1'b0;
        end else if (w_is_halt) begin
          w_state_next = FS_HALTED;
        end else begin
          w_accept  = 1'b1;
          w_flush   = 1'b0;
          w_pc_next = r_pc + ADDR_W'(1);
        end
      end
      FS_HALTED: begin
        if (Redirect) begin
          w_pc_next    = RedirectTarget;
          w_state_next = FS_RUN;
        end
      end
      default: w_state_next = FS_IDLE;
    endcase
  end

  // PC register; wraps modulo 2**ADDR_W.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) r_pc <= RESET_PC;
    else         r_pc <= w_pc_next;
  end

  // Accepted-fetch counter, saturating at all-ones.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)                      r_cnt <= '0;
    else if (w_accept && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  if_id_register #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .i_clk   (Clk),
    .i_rst_n (ResetN),
    .i_flush (w_flush),
    .i_load  (w_accept),
    .i_instr (imem.Instruction),
    .i_pc    (r_pc),
    .o_valid (IfValid),
    .o_instr (IfInstruction),
    .o_pc    (IfPc)
  );

  assign imem.ReadAddress = r_pc;
  assign Halted           = (r_state == FS_HALTED);
  assign FetchCount       = r_cnt;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural memory returns
// address+1, a reference model tracks PC/state/count, and accepted fetches are
// queued in a scoreboard and popped when the IF/ID register should show them.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        Start, Stall, Redirect;
  logic [5:0]  RedirectTarget;
  logic        IfValid;
  logic [31:0] IfInstruction;
  logic [5:0]  IfPc;
  logic        Halted;
  logic [3:0]  FetchCount;

  logic [31:0] mem [64];

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [5:0]  pc;
    logic [31:0] w;
  } fetch_t;
  fetch_t sb[$];

  // reference model: 0=IDLE 1=RUN 2=HALTED
  int unsigned m_state;
  logic [5:0]  m_pc;
  logic [3:0]  m_cnt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [5:0]  m_ifpc;

  instruction_fetch_unit_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  assign bus.Instruction = mem[bus.ReadAddress];

  instruction_fetch_unit #(
    .ADDR_W    (6),
    .DATA_W    (32),
    .RESET_PC  (6'h00),
    .HALT_WORD (HALT),
    .CNT_W     (4)
  ) dut (
    .Clk            (Clk),
    .ResetN         (ResetN),
    .Start          (Start),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .imem           (bus),
    .IfValid        (IfValid),
    .IfInstruction  (IfInstruction),
    .IfPc           (IfPc),
    .Halted         (Halted),
    .FetchCount     (FetchCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 6'h00; m_cnt = '0;
    m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
    sb.delete();
  endtask

  // One clock: drive inputs after negedge, advance model, check #1 after posedge.
  task automatic step(input logic st, input logic sl, input logic rd, input logic [5:0] tg);
    logic [31:0] w;
    fetch_t      e;
    @(negedge Clk);
    Start = st; Stall = sl; Redirect = rd; RedirectTarget = tg;
    w = mem[m_pc];
    case (m_state)
      0: begin
        if (rd) m_pc = tg;
        if (st) m_state = 1;
        m_valid = 1'b0;
      end
      1: begin
        if (rd) begin
          m_pc = tg; m_valid = 1'b0;
        end else if (sl) begin
          // hold everything
        end else if (w == HALT) begin
          m_state = 2; m_valid = 1'b0;
        end else begin
          sb.push_back('{pc: m_pc, w: w});
          m_instr = w; m_ifpc = m_pc; m_valid = 1'b1;
          m_pc = m_pc + 6'd1;
          if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
      end
      default: begin
        if (rd) begin m_pc = tg; m_state = 1; end
        m_valid = 1'b0;
      end
    endcase
    @(posedge Clk); #1;
    chk("read_address", {26'd0, bus.ReadAddress}, {26'd0, m_pc});
    chk("if_valid", {31'd0, IfValid}, {31'd0, m_valid});
    chk("halted", {31'd0, Halted}, {31'd0, (m_state == 2)});
    chk("fetch_count", {28'd0, FetchCount}, {28'd0, m_cnt});
    chk("if_instr_held", IfInstruction, m_instr);
    chk("if_pc_held", {26'd0, IfPc}, {26'd0, m_ifpc});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_instr", IfInstruction, e.w);
      chk("sb_pc", {26'd0, IfPc}, {26'd0, e.pc});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
    ResetN = 1'b0; Start = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = '0;
    model_reset();
    #12;
    chk("rst_ra", {26'd0, bus.ReadAddress}, 32'h0);
    chk("rst_valid", {31'd0, IfValid}, 32'h0);
    chk("rst_instr", IfInstruction, 32'h0);
    chk("rst_halted", {31'd0, Halted}, 32'h0);
    chk("rst_count", {28'd0, FetchCount}, 32'h0);
    @(negedge Clk); ResetN = 1'b1;

    // sequential fetch
    step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("t1_valid_start", {31'd0, IfValid}, 32'h0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("t1_instr", IfInstruction, 32'd5);
    chk("t1_ra", {26'd0, bus.ReadAddress}, 32'd5);

    // stall at PC=5
    repeat (3) step(1'b0, 1'b1, 1'b0, 6'h00);
    chk("t2_ra", {26'd0, bus.ReadAddress}, 32'd5);
    chk("t2_ifpc", {26'd0, IfPc}, 32'd4);
    chk("t2_count", {28'd0, FetchCount}, 32'd5);
    repeat (4) step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("t2_resume_ra", {26'd0, bus.ReadAddress}, 32'd9);

    // redirect at PC=9
    step(1'b0, 1'b0, 1'b1, 6'h20);
    chk("t3_valid", {31'd0, IfValid}, 32'h0);
    chk("t3_ra", {26'd0, bus.ReadAddress}, 32'h20);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("t3_ifpc", {26'd0, IfPc}, 32'h20);
    step(1'b0, 1'b1, 1'b1, 6'h3E);
    chk("t3_rs_ra", {26'd0, bus.ReadAddress}, 32'h3E);

    // wrap at 3F
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("t4_ra_wrap", {26'd0, bus.ReadAddress}, 32'h00);
    chk("t4_ifpc", {26'd0, IfPc}, 32'h3F);
    chk("t4_valid", {31'd0, IfValid}, 32'h1);

    // counter saturation (4-bit instance)
    repeat (5) step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("sat_count", {28'd0, FetchCount}, 32'hF);

    // halt at address 7
    @(negedge Clk); ResetN = 1'b0; model_reset();
    @(negedge Clk); ResetN = 1'b1;
    mem[7] = HALT;
    step(1'b1, 1'b0, 1'b0, 6'h00);
    repeat (7) step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b0, 1'b1, 1'b0, 6'h00);
    chk("t5_stall_no_halt", {31'd0, Halted}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("t5_halted", {31'd0, Halted}, 32'h1);
    chk("t5_ra", {26'd0, bus.ReadAddress}, 32'd7);
    chk("t5_valid", {31'd0, IfValid}, 32'h0);
    chk("t5_count", {28'd0, FetchCount}, 32'd7);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b0, 1'b0, 1'b1, 6'h00);
    chk("t5_unhalt", {31'd0, Halted}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("t5_resume_instr", IfInstruction, 32'd1);

    // async reset between edges
    step(1'b0, 1'b0, 1'b0, 6'h00);
    @(posedge Clk); #3;
    ResetN = 1'b0;
    #1;
    chk("t6_ra", {26'd0, bus.ReadAddress}, 32'h0);
    chk("t6_valid", {31'd0, IfValid}, 32'h0);
    chk("t6_instr", IfInstruction, 32'h0);
    chk("t6_count", {28'd0, FetchCount}, 32'h0);
    model_reset();
    @(negedge Clk); ResetN = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("t6_idle_ra", {26'd0, bus.ReadAddress}, 32'h0);

    // redirect in IDLE, then Start+Redirect
    step(1'b0, 1'b0, 1'b1, 6'h10);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("idle_redirect_ra", {26'd0, bus.ReadAddress}, 32'h10);
    step(1'b1, 1'b0, 1'b1, 6'h30);
    chk("start_redir_valid", {31'd0, IfValid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("start_redir_instr", IfInstruction, 32'h31);

    @(negedge Clk); Start = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
